// File: rtl/riscv_multi_cycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : riscv_multi_cycle_controller_if
// Purpose  : Bundle between the multi-cycle controller and the datapath.
//            The controller receives the instruction fields and ALU flags.
//            It returns the per-cycle enables and mux selects.
// Revision : 1.0 - initial release
// ============================================================================
interface riscv_multi_cycle_controller_if;
  logic [6:0] opc;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       zero;
  logic       pos;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_cntl;
  logic [2:0] imm_src;

  // Controller side
  modport master (
    input  opc, func3, func7, zero, pos,
    output pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_cntl, imm_src
  );

  // Datapath side
  modport slave (
    output opc, func3, func7, zero, pos,
    input  pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, alu_cntl, imm_src
  );
endinterface
`default_nettype wire

// File: rtl/riscv_multi_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : riscv_multi_cycle_controller
// Purpose  : Moore FSM that sequences a shared-memory, shared-ALU RV32I
//            datapath. Each instruction takes 3 to 5 clocks.
// Options  : RISCV_MC_HALT_EN - when defined, the ILLEGAL state is sticky and
//            a halt output is provided. When undefined, an illegal
//            instruction behaves as a one-cycle NOP.
// Revision : 1.0 - initial release
// ============================================================================
module riscv_multi_cycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  riscv_multi_cycle_controller_if.master bus,
`ifdef RISCV_MC_HALT_EN
  output logic                           halt,
`endif
  output logic [STATE_W-1:0]             state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_ALU_WB    = 4'd4,
    S_MEM_ADR   = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR_ADR  = 4'd11,
    S_JALR_PC   = 4'd12,
    S_LUI       = 4'd13,
    S_ILLEGAL   = 4'd14
  } state_t;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  state_t     state;
  logic [2:0] alu_op;    // ALU operation captured in DECODE for EXEC_R/EXEC_I
  logic       is_store;  // load/store selector captured in DECODE
  logic [2:0] br_f3;     // branch condition captured in DECODE

  logic       is_r;
  logic [2:0] dec_alu;
  logic       dec_alu_ok;
  logic       dec_br_ok;
  logic       br_taken;

  // Decode ALU operation and legality of func3/func7 while in DECODE
  always_comb begin
    is_r       = (bus.opc == OPC_R);
    dec_alu    = ALU_ADD;
    dec_alu_ok = 1'b1;
    case (bus.func3)
      3'b000:  dec_alu = (is_r && bus.func7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
      3'b111:  dec_alu = ALU_AND;
      3'b110:  dec_alu = ALU_OR;
      3'b100:  dec_alu = ALU_XOR;
      3'b010:  dec_alu = ALU_SLT;
      3'b011:  dec_alu = ALU_SLTU;
      default: dec_alu_ok = 1'b0;
    endcase
    if (is_r && bus.func7 != 7'b0000000 && bus.func7 != 7'b0100000)
      dec_alu_ok = 1'b0;
    dec_br_ok = (bus.func3 == 3'b000) || (bus.func3 == 3'b001) ||
                (bus.func3 == 3'b100) || (bus.func3 == 3'b101);
  end

  // Branch condition from the flags of the subtraction running this cycle
  always_comb begin
    case (br_f3)
      3'b000:  br_taken = bus.zero;
      3'b001:  br_taken = !bus.zero;
      3'b100:  br_taken = !bus.pos;
      3'b101:  br_taken = bus.pos;
      default: br_taken = 1'b0;
    endcase
  end

  // State register plus the decode results carried into later states
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FETCH;
      alu_op   <= ALU_ADD;
      is_store <= 1'b0;
      br_f3    <= 3'b000;
    end else begin
      case (state)
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          alu_op   <= dec_alu;
          is_store <= bus.opc[5];
          br_f3    <= bus.func3;
          case (bus.opc)
            OPC_R, OPC_I:        state <= dec_alu_ok ? (is_r ? S_EXEC_R : S_EXEC_I) : S_ILLEGAL;
            OPC_LOAD, OPC_STORE: state <= S_MEM_ADR;
            OPC_BR:              state <= dec_br_ok ? S_BRANCH : S_ILLEGAL;
            OPC_JAL:             state <= S_JAL;
            OPC_JALR:            state <= S_JALR_ADR;
            OPC_LUI:             state <= S_LUI;
            default:             state <= S_ILLEGAL;
          endcase
        end
        S_EXEC_R:    state <= S_ALU_WB;
        S_EXEC_I:    state <= S_ALU_WB;
        S_ALU_WB:    state <= S_FETCH;
        S_MEM_ADR:   state <= is_store ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  state <= S_MEM_WB;
        S_MEM_WB:    state <= S_FETCH;
        S_MEM_WRITE: state <= S_FETCH;
        S_BRANCH:    state <= S_FETCH;
        S_JAL:       state <= S_ALU_WB;
        S_JALR_ADR:  state <= S_JALR_PC;
        S_JALR_PC:   state <= S_ALU_WB;
        S_LUI:       state <= S_FETCH;
`ifdef RISCV_MC_HALT_EN
        S_ILLEGAL:   state <= S_ILLEGAL;
`else
        S_ILLEGAL:   state <= S_FETCH;
`endif
        default:     state <= S_FETCH;
      endcase
    end
  end

  // Output decode from state; everything is held at zero while rst is low
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.result_src = 2'b00;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_cntl   = ALU_ADD;
    bus.imm_src    = IMM_I;
    state_dbg      = '0;
    if (rst) begin
      state_dbg = STATE_W'(state);
      case (state)
        S_FETCH: begin
          bus.ir_write = 1'b1; bus.pc_write = 1'b1;
          bus.alu_src_b = 2'b10; bus.result_src = 2'b10;
        end
        S_DECODE: begin
          bus.alu_src_a = 2'b01; bus.alu_src_b = 2'b01;
          bus.imm_src = (bus.opc == OPC_JAL) ? IMM_J : IMM_B;
        end
        S_EXEC_R: begin
          bus.alu_src_a = 2'b10; bus.alu_cntl = alu_op;
        end
        S_EXEC_I: begin
          bus.alu_src_a = 2'b10; bus.alu_src_b = 2'b01; bus.alu_cntl = alu_op;
        end
        S_ALU_WB: bus.reg_write = 1'b1;
        S_MEM_ADR: begin
          bus.alu_src_a = 2'b10; bus.alu_src_b = 2'b01;
          bus.imm_src = is_store ? IMM_S : IMM_I;
        end
        S_MEM_READ: bus.adr_src = 1'b1;
        S_MEM_WB: begin
          bus.result_src = 2'b01; bus.reg_write = 1'b1;
        end
        S_MEM_WRITE: begin
          bus.adr_src = 1'b1; bus.mem_write = 1'b1;
        end
        S_BRANCH: begin
          bus.alu_src_a = 2'b10; bus.alu_cntl = ALU_SUB; bus.pc_write = br_taken;
        end
        S_JAL, S_JALR_PC: begin
          bus.pc_write = 1'b1; bus.alu_src_a = 2'b01; bus.alu_src_b = 2'b10;
        end
        S_JALR_ADR: begin
          bus.alu_src_a = 2'b10; bus.alu_src_b = 2'b01;
        end
        S_LUI: begin
          bus.imm_src = IMM_U; bus.result_src = 2'b11; bus.reg_write = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef RISCV_MC_HALT_EN
  // Halt flag while parked in ILLEGAL
  always_comb halt = rst && (state == S_ILLEGAL);
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_multi_cycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_multi_cycle_controller
// Purpose  : Directed self-checking bench for riscv_multi_cycle_controller.
// Options  : RISCV_MC_HALT_EN selects the sticky-ILLEGAL checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_multi_cycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] state_dbg;
`ifdef RISCV_MC_HALT_EN
  logic       halt;
`endif
  int n_run  = 0;
  int n_fail = 0;

  riscv_multi_cycle_controller_if bus ();

  riscv_multi_cycle_controller #(.STATE_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.master),
`ifdef RISCV_MC_HALT_EN
    .halt      (halt),
`endif
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, a, b, alu, imm}
  logic [16:0] ctrl_obs;
  assign ctrl_obs = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write,
                     bus.reg_write, bus.result_src, bus.alu_src_a, bus.alu_src_b,
                     bus.alu_cntl, bus.imm_src};

  localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1, ST_EXEC_R = 4'd2,
                         ST_EXEC_I = 4'd3, ST_ALU_WB = 4'd4, ST_MEM_ADR = 4'd5,
                         ST_MEM_READ = 4'd6, ST_MEM_WB = 4'd7, ST_MEM_WRITE = 4'd8,
                         ST_BRANCH = 4'd9, ST_JAL = 4'd10, ST_JALR_ADR = 4'd11,
                         ST_JALR_PC = 4'd12, ST_LUI = 4'd13, ST_ILLEGAL = 4'd14;

  localparam logic [16:0] C_ZERO    = 17'd0;
  localparam logic [16:0] C_FETCH   = {5'b10010, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000};
  localparam logic [16:0] C_DEC_B   = {5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b010};
  localparam logic [16:0] C_DEC_J   = {5'b00000, 2'b00, 2'b01, 2'b01, 3'b000, 3'b011};
  localparam logic [16:0] C_EXR_SUB = {5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000};
  localparam logic [16:0] C_EXR_SLT = {5'b00000, 2'b00, 2'b10, 2'b00, 3'b101, 3'b000};
  localparam logic [16:0] C_EXI_AND = {5'b00000, 2'b00, 2'b10, 2'b01, 3'b010, 3'b000};
  localparam logic [16:0] C_ALU_WB  = {5'b00001, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
  localparam logic [16:0] C_MADR_L  = {5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000};
  localparam logic [16:0] C_MADR_S  = {5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b001};
  localparam logic [16:0] C_MREAD   = {5'b01000, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
  localparam logic [16:0] C_MWB     = {5'b00001, 2'b01, 2'b00, 2'b00, 3'b000, 3'b000};
  localparam logic [16:0] C_MWRITE  = {5'b01100, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000};
  localparam logic [16:0] C_BR_T    = {5'b10000, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000};
  localparam logic [16:0] C_BR_N    = {5'b00000, 2'b00, 2'b10, 2'b00, 3'b001, 3'b000};
  localparam logic [16:0] C_JUMP_PC = {5'b10000, 2'b00, 2'b01, 2'b10, 3'b000, 3'b000};
  localparam logic [16:0] C_JADR    = {5'b00000, 2'b00, 2'b10, 2'b01, 3'b000, 3'b000};
  localparam logic [16:0] C_LUI     = {5'b00001, 2'b11, 2'b00, 2'b00, 3'b000, 3'b100};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check state and control word at the current time
  task automatic look(input string tag, input logic [3:0] st, input logic [16:0] c);
    chk({tag, " state"}, {28'd0, state_dbg}, {28'd0, st});
    chk({tag, " ctrl"}, {15'd0, ctrl_obs}, {15'd0, c});
  endtask

  // Advance one clock and check, sampling on the falling edge
  task automatic step(input string tag, input logic [3:0] st, input logic [16:0] c);
    @(negedge clk);
    look(tag, st, c);
  endtask

  task automatic set_ir(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
    bus.opc = o; bus.func3 = f3; bus.func7 = f7;
  endtask

  initial begin
    rst = 1'b0; set_ir(7'd0, 3'd0, 7'd0); bus.zero = 1'b0; bus.pos = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    look("reset", ST_FETCH, C_ZERO);
    rst = 1'b1;
    #1 look("release", ST_FETCH, C_FETCH);

    // R-type sub
    set_ir(7'b0110011, 3'b000, 7'b0100000);
    step("sub decode", ST_DECODE, C_DEC_B);
    step("sub exec", ST_EXEC_R, C_EXR_SUB);
    step("sub wb", ST_ALU_WB, C_ALU_WB);
    step("sub fetch", ST_FETCH, C_FETCH);

    // R-type slt
    set_ir(7'b0110011, 3'b010, 7'b0000000);
    step("slt decode", ST_DECODE, C_DEC_B);
    step("slt exec", ST_EXEC_R, C_EXR_SLT);
    step("slt wb", ST_ALU_WB, C_ALU_WB);
    step("slt fetch", ST_FETCH, C_FETCH);

    // I-type andi (func7 field ignored for I-type)
    set_ir(7'b0010011, 3'b111, 7'b0100000);
    step("andi decode", ST_DECODE, C_DEC_B);
    step("andi exec", ST_EXEC_I, C_EXI_AND);
    step("andi wb", ST_ALU_WB, C_ALU_WB);
    step("andi fetch", ST_FETCH, C_FETCH);

    // Load: 5 cycles
    set_ir(7'b0000011, 3'b010, 7'd0);
    step("lw decode", ST_DECODE, C_DEC_B);
    step("lw adr", ST_MEM_ADR, C_MADR_L);
    step("lw read", ST_MEM_READ, C_MREAD);
    step("lw wb", ST_MEM_WB, C_MWB);
    step("lw fetch", ST_FETCH, C_FETCH);

    // Store: 4 cycles
    set_ir(7'b0100011, 3'b010, 7'd0);
    step("sw decode", ST_DECODE, C_DEC_B);
    step("sw adr", ST_MEM_ADR, C_MADR_S);
    step("sw write", ST_MEM_WRITE, C_MWRITE);
    step("sw fetch", ST_FETCH, C_FETCH);

    // blt: taken when result negative, not taken when positive
    set_ir(7'b1100011, 3'b100, 7'd0); bus.zero = 1'b0; bus.pos = 1'b0;
    step("blt decode", ST_DECODE, C_DEC_B);
    step("blt taken", ST_BRANCH, C_BR_T);
    bus.pos = 1'b1;
    #1 look("blt not taken", ST_BRANCH, C_BR_N);
    step("blt fetch", ST_FETCH, C_FETCH);

    // beq: taken only when zero
    set_ir(7'b1100011, 3'b000, 7'd0); bus.zero = 1'b1;
    step("beq decode", ST_DECODE, C_DEC_B);
    step("beq taken", ST_BRANCH, C_BR_T);
    bus.zero = 1'b0;
    #1 look("beq not taken", ST_BRANCH, C_BR_N);
    step("beq fetch", ST_FETCH, C_FETCH);

    // jal
    set_ir(7'b1101111, 3'b000, 7'd0);
    step("jal decode", ST_DECODE, C_DEC_J);
    step("jal pc", ST_JAL, C_JUMP_PC);
    step("jal wb", ST_ALU_WB, C_ALU_WB);
    step("jal fetch", ST_FETCH, C_FETCH);

    // jalr
    set_ir(7'b1100111, 3'b000, 7'd0);
    step("jalr decode", ST_DECODE, C_DEC_B);
    step("jalr adr", ST_JALR_ADR, C_JADR);
    step("jalr pc", ST_JALR_PC, C_JUMP_PC);
    step("jalr wb", ST_ALU_WB, C_ALU_WB);
    step("jalr fetch", ST_FETCH, C_FETCH);

    // lui
    set_ir(7'b0110111, 3'b000, 7'd0);
    step("lui decode", ST_DECODE, C_DEC_B);
    step("lui", ST_LUI, C_LUI);
    step("lui fetch", ST_FETCH, C_FETCH);

    // Reset asserted in MEM_READ abandons the load
    set_ir(7'b0000011, 3'b010, 7'd0);
    step("rst lw decode", ST_DECODE, C_DEC_B);
    step("rst lw adr", ST_MEM_ADR, C_MADR_L);
    step("rst lw read", ST_MEM_READ, C_MREAD);
    #2 rst = 1'b0;
    #1 look("mid reset", ST_FETCH, C_ZERO);
    @(negedge clk);
    rst = 1'b1;
    #1 look("mid release", ST_FETCH, C_FETCH);

`ifndef RISCV_MC_HALT_EN
    // Illegal func3 on R-type goes straight to ILLEGAL, then NOP back to FETCH
    set_ir(7'b0110011, 3'b001, 7'd0);
    step("bad f3 decode", ST_DECODE, C_DEC_B);
    step("bad f3 illegal", ST_ILLEGAL, C_ZERO);
    step("bad f3 fetch", ST_FETCH, C_FETCH);

    // Illegal branch func3
    set_ir(7'b1100011, 3'b010, 7'd0);
    step("bad br decode", ST_DECODE, C_DEC_B);
    step("bad br illegal", ST_ILLEGAL, C_ZERO);
    step("bad br fetch", ST_FETCH, C_FETCH);

    // Unknown opcode
    set_ir(7'b1111111, 3'b000, 7'd0);
    step("bad opc decode", ST_DECODE, C_DEC_B);
    step("bad opc illegal", ST_ILLEGAL, C_ZERO);
    step("bad opc fetch", ST_FETCH, C_FETCH);
`else
    // Unknown opcode parks in ILLEGAL with halt until reset
    set_ir(7'b1111111, 3'b000, 7'd0);
    step("halt decode", ST_DECODE, C_DEC_B);
    chk("halt decode flag", {31'd0, halt}, 32'd0);
    step("halt enter", ST_ILLEGAL, C_ZERO);
    chk("halt enter flag", {31'd0, halt}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step("halt hold", ST_ILLEGAL, C_ZERO);
      chk("halt hold flag", {31'd0, halt}, 32'd1);
    end
    rst = 1'b0;
    #1 look("halt reset", ST_FETCH, C_ZERO);
    chk("halt reset flag", {31'd0, halt}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 look("halt release", ST_FETCH, C_FETCH);
    chk("halt release flag", {31'd0, halt}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
